// File: rtl/ts_q_arb.sv
// Two-queue timestamp arbiter: pops one record per pass from the RX or TX queue
// (round-robin on ties), presents it on a valid/ready port and counts deliveries.
module ts_q_arb #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_in,
  input  logic        clr_in,
  input  logic [7:0]  rx_q_stat_in,
  input  logic [55:0] rx_q_data_in,
  output logic        rx_q_rd_en_out,
  input  logic [7:0]  tx_q_stat_in,
  input  logic [55:0] tx_q_data_in,
  output logic        tx_q_rd_en_out,
  output logic        ts_valid_out,
  input  logic        ts_ready_in,
  output logic [55:0] ts_data_out,
  output logic        ts_src_out,
  output logic [15:0] rx_cnt_out,
  output logic [15:0] tx_cnt_out
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, VALID} state_t;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  state_t     state;
  logic       last_src;
  logic       sel_src;
  logic [1:0] wait_cnt;
  logic       rx_elig;
  logic       tx_elig;
  logic       grant_src;
  logic       hs;

  function automatic logic [15:0] cnt_next(input logic [15:0] cnt, input logic clr,
                                           input logic inc);
    if (clr) return 16'd0;
    return cnt + {15'd0, inc};
  endfunction

  assign rx_elig   = en_in && (rx_q_stat_in != 8'd0);
  assign tx_elig   = en_in && (tx_q_stat_in != 8'd0);
  // On a tie the source that was not served last wins; otherwise the only eligible one.
  assign grant_src = (rx_elig && tx_elig) ? ~last_src : tx_elig;
  assign hs        = ts_valid_out && ts_ready_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rx_q_rd_en_out <= 1'b0;
      tx_q_rd_en_out <= 1'b0;
      ts_valid_out   <= 1'b0;
      ts_data_out    <= 56'd0;
      ts_src_out     <= 1'b0;
      rx_cnt_out     <= 16'd0;
      tx_cnt_out     <= 16'd0;
      last_src       <= 1'b1;
      sel_src        <= 1'b0;
      wait_cnt       <= 2'd0;
    end else begin
      if (clr_in || (hs && !ts_src_out))
        rx_cnt_out <= cnt_next(rx_cnt_out, clr_in, hs && !ts_src_out);
      if (clr_in || (hs && ts_src_out))
        tx_cnt_out <= cnt_next(tx_cnt_out, clr_in, hs && ts_src_out);

      case (state)
        IDLE: begin
          if (rx_elig || tx_elig) begin
            sel_src        <= grant_src;
            rx_q_rd_en_out <= ~grant_src;
            tx_q_rd_en_out <= grant_src;
            state          <= READ;
          end
        end
        READ: begin
          rx_q_rd_en_out <= 1'b0;
          tx_q_rd_en_out <= 1'b0;
          wait_cnt       <= WAIT_LAST;
          state          <= WAIT;
        end
        WAIT: begin
          // Queue data is valid in the last WAIT cycle; capture it on that edge.
          if (wait_cnt == 2'd0) begin
            ts_data_out  <= sel_src ? tx_q_data_in : rx_q_data_in;
            ts_src_out   <= sel_src;
            ts_valid_out <= 1'b1;
            state        <= VALID;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        VALID: begin
          if (ts_ready_in) begin
            ts_valid_out <= 1'b0;
            last_src     <= ts_src_out;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ts_q_arb.sv
// Bench for ts_q_arb: two instances (RD_LAT=1 and RD_LAT=3) checked every cycle against
// a record-timeline reference model, plus an arbitration table and directed corner cases.
module tb_ts_q_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, clr, rdy;
  logic [7:0]  rxs[2], txs[2];
  logic [55:0] rxd[2], txd[2];
  logic        rxe[2], txe[2], vld[2], src[2];
  logic [55:0] dat[2];
  logic [15:0] rxc[2], txc[2];

  ts_q_arb #(.RD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .en_in(en), .clr_in(clr),
    .rx_q_stat_in(rxs[0]), .rx_q_data_in(rxd[0]), .rx_q_rd_en_out(rxe[0]),
    .tx_q_stat_in(txs[0]), .tx_q_data_in(txd[0]), .tx_q_rd_en_out(txe[0]),
    .ts_valid_out(vld[0]), .ts_ready_in(rdy), .ts_data_out(dat[0]), .ts_src_out(src[0]),
    .rx_cnt_out(rxc[0]), .tx_cnt_out(txc[0]));

  ts_q_arb #(.RD_LAT(3)) u1 (
    .clk(clk), .rst(rst), .en_in(en), .clr_in(clr),
    .rx_q_stat_in(rxs[1]), .rx_q_data_in(rxd[1]), .rx_q_rd_en_out(rxe[1]),
    .tx_q_stat_in(txs[1]), .tx_q_data_in(txd[1]), .tx_q_rd_en_out(txe[1]),
    .ts_valid_out(vld[1]), .ts_ready_in(rdy), .ts_data_out(dat[1]), .ts_src_out(src[1]),
    .rx_cnt_out(rxc[1]), .tx_cnt_out(txc[1]));

  localparam int S_IDLE = 0, S_POP = 1, S_WT = 2, S_VAL = 3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Queue models: fill level and index of the next entry to be popped.
  int qcnt[2][2];
  int pk_next[2][2];

  // Reference model of each instance's record timeline.
  int          m_st[2], m_wl[2], m_pk[2], m_pend[2];
  logic        m_g[2], m_last[2], m_rchk[2];
  logic [15:0] m_cnt[2][2];
  logic [55:0] m_dat[2];

  // Observations of the DUT outputs taken at the negative edge.
  int   obs_pop[2], npop[2];
  logic obs_src[2], obs_vld[2];
  int   pc0[$], pc1[$];
  logic ps0[$], ps1[$];

  typedef struct {
    logic e;
    int   rxn;
    int   txn;
    int   exp;  // 0 = RX grant, 1 = TX grant, 2 = no grant
  } vec_t;
  vec_t tbl[10];

  function automatic logic [55:0] mk(input int i, input int s, input int k);
    return {4'hC, 4'(i), 4'(s), 12'(k), 32'(k) * 32'h9E3779B1};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model(input int i);
    int   lat;
    logic hs;
    lat = (i == 0) ? 1 : 3;
    hs  = 1'b0;
    chk("rx_cnt", rxc[i], m_cnt[i][0]);
    chk("tx_cnt", txc[i], m_cnt[i][1]);
    chk("rd_excl", rxe[i] & txe[i], 0);
    if (rxe[i] || txe[i]) begin
      npop[i]++;
      obs_pop[i] = cyc;
      obs_src[i] = txe[i];
      if (i == 0) begin pc0.push_back(cyc); ps0.push_back(txe[i]); end
      else begin pc1.push_back(cyc); ps1.push_back(txe[i]); end
    end
    obs_vld[i] = vld[i];
    case (m_st[i])
      S_IDLE: begin
        chk("idle_rx_rd", rxe[i], 0);
        chk("idle_tx_rd", txe[i], 0);
        chk("idle_vld", vld[i], 0);
        if (m_rchk[i]) begin
          chk("rst_dat", dat[i], 0);
          chk("rst_src", src[i], 0);
          m_rchk[i] = 1'b0;
        end
        if (!rst && en && (rxs[i] != 0 || txs[i] != 0)) begin
          m_g[i]  = (rxs[i] != 0 && txs[i] != 0) ? !m_last[i] : (txs[i] != 0);
          m_st[i] = S_POP;
        end
      end
      S_POP: begin
        chk("pop_rx_rd", rxe[i], !m_g[i]);
        chk("pop_tx_rd", txe[i], m_g[i]);
        chk("pop_vld", vld[i], 0);
        m_pk[i] = pk_next[i][m_g[i]];
        pk_next[i][m_g[i]]++;
        if (qcnt[i][m_g[i]] > 0) qcnt[i][m_g[i]]--;
        m_pend[i] = cyc + lat;
        m_wl[i]   = lat;
        m_st[i]   = S_WT;
      end
      S_WT: begin
        chk("wait_rx_rd", rxe[i], 0);
        chk("wait_tx_rd", txe[i], 0);
        chk("wait_vld", vld[i], 0);
        m_wl[i]--;
        if (m_wl[i] == 0) begin
          m_st[i]  = S_VAL;
          m_dat[i] = mk(i, int'(m_g[i]), m_pk[i]);
        end
      end
      default: begin
        chk("valid_vld", vld[i], 1);
        chk("valid_dat", dat[i], m_dat[i]);
        chk("valid_src", src[i], m_g[i]);
        chk("valid_rx_rd", rxe[i], 0);
        chk("valid_tx_rd", txe[i], 0);
        if (rdy) begin
          hs        = 1'b1;
          m_last[i] = m_g[i];
          m_st[i]   = S_IDLE;
        end
      end
    endcase
    if (rst || clr) begin
      m_cnt[i][0] = 16'd0;
      m_cnt[i][1] = 16'd0;
    end else if (hs) begin
      m_cnt[i][m_g[i]] = m_cnt[i][m_g[i]] + 16'd1;
    end
    if (rst) begin
      m_st[i]   = S_IDLE;
      m_last[i] = 1'b1;
      m_rchk[i] = 1'b1;
      m_pend[i] = -1;
    end
  endtask

  task automatic step();
    for (int i = 0; i < 2; i++) begin
      rxs[i] = (qcnt[i][0] > 255) ? 8'd255 : 8'(qcnt[i][0]);
      txs[i] = (qcnt[i][1] > 255) ? 8'd255 : 8'(qcnt[i][1]);
    end
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) model(i);
    @(posedge clk);
    #1;
    // Queue data is only meaningful exactly RD_LAT cycles after the pop.
    for (int i = 0; i < 2; i++) begin
      rxd[i] = (m_pend[i] == cyc + 1 && !m_g[i]) ? mk(i, 0, m_pk[i]) : 56'({$urandom(), $urandom()});
      txd[i] = (m_pend[i] == cyc + 1 && m_g[i]) ? mk(i, 1, m_pk[i]) : 56'({$urandom(), $urandom()});
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_q(input int rxn, input int txn);
    for (int i = 0; i < 2; i++) begin
      qcnt[i][0] = rxn;
      qcnt[i][1] = txn;
    end
  endtask

  task automatic wait_state(input int i, input int s, input string nm);
    int t;
    t = 0;
    while (m_st[i] != s && t < 40) begin step(); t++; end
    chk(nm, m_st[i] == s, 1);
  endtask

  task automatic wait_vld(input int i, input string nm);
    int t;
    t = 0;
    while (!obs_vld[i] && t < 40) begin step(); t++; end
    chk(nm, obs_vld[i], 1);
  endtask

  initial begin
    int p0, v0, p1, v1, n, c1, got;
    tbl[0] = '{1'b1, 1, 0, 0};
    tbl[1] = '{1'b1, 0, 1, 1};
    tbl[2] = '{1'b1, 2, 2, 0};
    tbl[3] = '{1'b1, 2, 2, 1};
    tbl[4] = '{1'b1, 3, 5, 0};
    tbl[5] = '{1'b0, 4, 4, 2};
    tbl[6] = '{1'b1, 0, 0, 2};
    tbl[7] = '{1'b1, 255, 0, 0};
    tbl[8] = '{1'b1, 9, 9, 1};
    tbl[9] = '{1'b1, 1, 1, 0};

    rst = 1'b1; en = 1'b0; clr = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rxd[i] = 56'd0; txd[i] = 56'd0;
      m_st[i] = S_IDLE; m_last[i] = 1'b1; m_rchk[i] = 1'b1; m_pend[i] = -1;
      m_g[i] = 1'b0; m_wl[i] = 0; m_pk[i] = 0; m_dat[i] = 56'd0;
      m_cnt[i][0] = 16'd0; m_cnt[i][1] = 16'd0;
      obs_pop[i] = -1; npop[i] = 0; obs_src[i] = 1'b0; obs_vld[i] = 1'b0;
      for (int s = 0; s < 2; s++) begin qcnt[i][s] = 0; pk_next[i][s] = 0; end
    end
    steps(3);
    rst = 1'b0;
    steps(2);

    // Arbitration table, applied in order so the round-robin pointer carries over.
    foreach (tbl[r]) begin
      obs_pop[0] = -1;
      set_q(tbl[r].rxn, tbl[r].txn);
      en = tbl[r].e;
      for (int t = 0; t < 6 && obs_pop[0] < 0; t++) step();
      set_q(0, 0);
      got = (obs_pop[0] < 0) ? 2 : int'(obs_src[0]);
      chk("arb_vec", got, tbl[r].exp);
      steps(8);
    end

    // Single RX record: latency from pop to valid.
    clr = 1'b1; step(); clr = 1'b0;
    set_q(1, 0); en = 1'b1; rdy = 1'b1;
    p0 = -1; v0 = -1; p1 = -1; v1 = -1;
    for (int t = 0; t < 14; t++) begin
      step();
      if (p0 < 0 && obs_pop[0] == cyc) p0 = cyc;
      if (p1 < 0 && obs_pop[1] == cyc) p1 = cyc;
      if (v0 < 0 && obs_vld[0]) v0 = cyc;
      if (v1 < 0 && obs_vld[1]) v1 = cyc;
    end
    chk("lat1_valid", v0 - p0, 2);
    chk("lat3_valid", v1 - p1, 4);
    chk("single_rx_cnt", rxc[0], 1);

    // Six records from two full queues after reset: alternating, evenly spaced.
    rst = 1'b1; step(); rst = 1'b0;
    set_q(3, 3); en = 1'b1; rdy = 1'b1;
    pc0.delete(); ps0.delete(); pc1.delete(); ps1.delete();
    steps(45);
    chk("seq_len0", pc0.size(), 6);
    chk("seq_len1", pc1.size(), 6);
    for (int k = 0; k < 6 && k < pc0.size(); k++) begin
      chk("seq_src0", ps0[k], k % 2);
      if (k > 0) chk("seq_gap0", pc0[k] - pc0[k-1], 4);
    end
    for (int k = 1; k < 6 && k < pc1.size(); k++) chk("seq_gap1", pc1[k] - pc1[k-1], 6);
    chk("seq_rx_cnt", rxc[0], 3);
    chk("seq_tx_cnt", txc[0], 3);
    chk("seq_cnt1", {rxc[1], txc[1]}, {16'd3, 16'd3});

    // Consumer stall in VALID.
    set_q(1, 0); rdy = 1'b0;
    wait_vld(0, "stall_reach");
    n = npop[0];
    steps(20);
    chk("stall_vld", obs_vld[0], 1);
    chk("stall_nopop", npop[0] - n, 0);
    rdy = 1'b1;
    steps(8);
    chk("stall_cnt", rxc[0], 4);
    chk("stall_idle", obs_vld[0], 0);

    // Counter wrap and clear coincident with handshake.
    en = 1'b0; steps(3);
    m_cnt[0][0] = 16'hFFFF;
    force u0.rx_cnt_out = 16'hFFFF;
    step();
    release u0.rx_cnt_out;
    steps(2);
    qcnt[0][0] = 1; en = 1'b1;
    steps(8);
    chk("wrap_cnt", rxc[0], 0);
    qcnt[0][0] = 1; rdy = 1'b0;
    wait_vld(0, "clr_reach");
    rdy = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    chk("clr_hs_rx", rxc[0], 0);
    chk("clr_hs_vld", obs_vld[0], 0);
    en = 1'b0; steps(10);

    // Reset while the RD_LAT=3 instance is waiting on queue data.
    set_q(2, 2); en = 1'b1; rdy = 1'b1;
    wait_state(1, S_WT, "rst_reach_wait");
    rst = 1'b1; step(); rst = 1'b0;
    obs_pop[1] = -1;
    for (int t = 0; t < 10 && obs_pop[1] < 0; t++) step();
    chk("rst_tie_seen", obs_pop[1] >= 0, 1);
    chk("rst_tie_rx", obs_src[1], 0);
    en = 1'b0; set_q(0, 0); steps(10);

    // Disabled arbiter never pops; dropping enable mid-record still delivers it.
    set_q(4, 4); en = 1'b0;
    n = npop[0] + npop[1];
    steps(50);
    chk("en0_nopop", npop[0] + npop[1] - n, 0);
    en = 1'b1;
    wait_state(1, S_WT, "en_reach_wait");
    en = 1'b0;
    c1 = int'(rxc[1]) + int'(txc[1]);
    n = npop[1];
    steps(15);
    chk("en_drop_deliv", int'(rxc[1]) + int'(txc[1]) - c1, 1);
    chk("en_drop_pops", npop[1] - n, 0);

    // Randomized traffic.
    for (int t = 0; t < 2500; t++) begin
      en  = ($urandom() % 8) != 0;
      rdy = ($urandom() % 3) != 0;
      clr = ($urandom() % 40) == 0;
      rst = ($urandom() % 150) == 0;
      if (($urandom() % 6) == 0) qcnt[$urandom() % 2][$urandom() % 2] = int'($urandom() % 4);
      step();
    end
    rst = 1'b0; clr = 1'b0; en = 1'b0; rdy = 1'b1;
    steps(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ts_q_arb.md
TS_Q_ARB -- requirements
Module: ts_q_arb

Interface
REQ-001 Parameter RD_LAT, default 1, queue read latency in clk cycles from rd_en to valid data; legal range 1..3.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 en_in  input  1  enables new grants; 0 = finish current record, then stay idle.
REQ-005 clr_in  input  1  synchronous clear of both record counters.
REQ-006 rx_q_stat_in  input  8  RX timestamp queue fill level; nonzero means not empty.
REQ-007 rx_q_data_in  input  56  RX queue read data.
REQ-008 rx_q_rd_en_out  output  1  RX queue pop strobe.
REQ-009 tx_q_stat_in, tx_q_data_in, tx_q_rd_en_out  same as RX, for the TX queue.
REQ-010 ts_valid_out  output  1  record available.
REQ-011 ts_ready_in  input  1  consumer accepts record.
REQ-012 ts_data_out  output  56  captured timestamp record.
REQ-013 ts_src_out  output  1  record source: 0 = RX, 1 = TX.
REQ-014 rx_cnt_out, tx_cnt_out  output  16  delivered-record counters per source.

Function
REQ-015 FSM states: IDLE, READ, WAIT, VALID; exactly one queue is served per pass.
REQ-016 IDLE: a source is eligible when en_in=1 and its stat_in != 0; stat_in is sampled only in IDLE.
REQ-017 Arbitration: one source eligible -> grant it; both eligible -> grant the source not served last (round-robin); none eligible -> stay in IDLE.
REQ-018 Grant in IDLE cycle N-1 -> READ in cycle N with the granted rd_en_out high for exactly cycle N; the other rd_en_out stays 0.
REQ-019 WAIT lasts RD_LAT cycles, counted by an internal counter; granted q_data_in is captured at the end of cycle N+RD_LAT.
REQ-020 VALID: ts_valid_out=1 from cycle N+RD_LAT+1; ts_data_out and ts_src_out are held stable until handshake.
REQ-021 Handshake = ts_valid_out & ts_ready_in; on handshake the FSM returns to IDLE in the next cycle and the last-served pointer updates to ts_src_out.
REQ-022 Minimum spacing between consecutive rd_en pulses is RD_LAT+3 cycles when ts_ready_in is held at 1.
REQ-023 ts_valid_out does not depend combinationally on ts_ready_in; ts_ready_in=0 stalls indefinitely in VALID with no further pops.
REQ-024 en_in falling in READ, WAIT or VALID: the current record completes normally; no new grant is made.
REQ-025 Counter of ts_src_out increments by 1 on handshake and wraps 0xFFFF -> 0x0000.
REQ-026 clr_in=1 sets both counters to 0 in the next cycle; clr_in coincident with handshake: clear wins, count = 0.
REQ-027 rx_q_rd_en_out and tx_q_rd_en_out are never high in the same cycle.

Reset
REQ-028 rst=1 at any clock edge forces: state IDLE, both rd_en low, ts_valid_out 0, ts_data_out 0, ts_src_out 0, both counters 0, last-served pointer = TX, so RX wins the first tie.
REQ-029 Reset mid-operation abandons an in-flight record; the entry already popped is lost, and no pop is issued during reset.

Verification
REQ-030 RD_LAT=1, rx stat=1, tx stat=0, ready=1 -> rx rd_en pulse in cycle N, ts_valid in cycle N+2 with rx data, src=0, rx_cnt=1.
REQ-031 Both stat=3, ready=1, 6 records -> source order RX,TX,RX,TX,RX,TX; rd_en pulses spaced 4 cycles apart; both counters = 3.
REQ-032 ts_ready_in held 0 for 20 cycles during VALID -> valid stays 1, data stable, no rd_en; ready=1 -> one handshake, then IDLE.
REQ-033 rx_cnt preset to 0xFFFF by 65535 handshakes, then 1 more -> 0x0000; clr_in in the same cycle as a handshake -> 0.
REQ-034 RD_LAT=3, rst asserted in WAIT -> next cycle all outputs at reset values; first grant after reset goes to RX on a tie.
REQ-035 en_in=0 with both stat nonzero -> no rd_en for 50 cycles; en_in dropped during WAIT -> that record is delivered, then idle.
